// File: rtl/voting_pkg.sv
`default_nettype none
// ============================================================================
// Module   : voting_pkg
// Purpose  : Shared encodings for the vote registry (FSM states, winner and
//            candidate codes) plus the winner decision helper.
// Revision : 1.0 - initial release
// ============================================================================
package voting_pkg;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_CLOSED = 2'd2
  } state_t;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_A    = 2'b01;
  localparam logic [1:0] W_B    = 2'b10;
  localparam logic [1:0] W_TIE  = 2'b11;

  localparam logic CAND_A = 1'b0;
  localparam logic CAND_B = 1'b1;

  // Tallies are passed zero-extended so one helper serves any counter width.
  function automatic logic [1:0] pick_winner(input int unsigned a, input int unsigned b);
    logic [1:0] w;
    if (a == 0 && b == 0) w = W_NONE;
    else if (a > b)       w = W_A;
    else if (b > a)       w = W_B;
    else                  w = W_TIE;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vote_registry_if.sv
`default_nettype none
// ============================================================================
// Module   : vote_registry_if
// Purpose  : Handshake bundle between the voting controller side (master)
//            and the vote registry (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface vote_registry_if #(
  parameter int ID_W  = 4,
  parameter int CNT_W = 8
);
  // controller -> registry
  logic [ID_W-1:0]  id;
  logic             check;
  logic             vote_enable;
  logic             current_candidate;
  logic             mark_done;
  logic             close_poll;
  logic             clear_poll;
  // registry -> controller
  logic             id_valid;
  logic             id_used;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;
  logic [CNT_W-1:0] turnout;
  logic [1:0]       winner;
  logic             result_valid;
  logic             audit_ok;
  logic             dup_err;
  logic             poll_open;

  modport master (
    output id, check, vote_enable, current_candidate, mark_done, close_poll, clear_poll,
    input  id_valid, id_used, count_a, count_b, turnout, winner, result_valid,
           audit_ok, dup_err, poll_open
  );

  modport slave (
    input  id, check, vote_enable, current_candidate, mark_done, close_poll, clear_poll,
    output id_valid, id_used, count_a, count_b, turnout, winner, result_valid,
           audit_ok, dup_err, poll_open
  );
endinterface
`default_nettype wire

// File: rtl/vote_counter_sat.sv
`default_nettype none
// ============================================================================
// Module   : vote_counter_sat
// Purpose  : CNT_W-bit saturating up-counter with synchronous clear. The sat
//            flag records that an increment was lost at the ceiling.
// Revision : 1.0 - initial release
// ============================================================================
module vote_counter_sat #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             clr_i,
  input  wire logic             inc_i,
  output logic      [CNT_W-1:0] count_o,
  output logic                  sat_o
);

  logic [CNT_W-1:0] count_q;
  logic             sat_q;

  // Count up until all-ones, then hold and flag every further increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (clr_i) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (inc_i) begin
      if (count_q == {CNT_W{1'b1}}) sat_q <= 1'b1;
      else count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule
`default_nettype wire

// File: rtl/vote_registry.sv
`default_nettype none
// ============================================================================
// Module   : vote_registry
// Purpose  : Responder side of the voting handshake. Answers ID checks,
//            tallies votes, tracks used IDs and, on poll close, audits the
//            used-ID bitmap one index per cycle before publishing a result.
// Revision : 1.0 - initial release
// ============================================================================
module vote_registry
  import voting_pkg::*;
#(
  parameter int                    ID_W     = 4,
  parameter int                    CNT_W    = 8,
  parameter logic [(2**ID_W)-1:0]  REG_MASK = {(2**ID_W){1'b1}}
) (
  input wire logic        clk,
  input wire logic        reset_n,
  vote_registry_if.slave  bus
);

  localparam int NUM_IDS = 2**ID_W;

  state_t             state_q;
  logic [NUM_IDS-1:0] used_q;
  logic [ID_W-1:0]    latched_q;
  logic               id_valid_q;
  logic               id_used_q;
  logic [CNT_W-1:0]   turnout_q;
  logic               tsat_q;
  logic [ID_W:0]      scan_idx_q;
  logic [1:0]         winner_q;
  logic               result_valid_q;
  logic               audit_ok_q;
  logic               dup_err_q;
  logic               poll_open_q;

  logic [CNT_W-1:0]   count_a_w;
  logic [CNT_W-1:0]   count_b_w;
  logic               sat_a_w;
  logic               sat_b_w;
  logic               inc_a_w;
  logic               inc_b_w;
  logic               clr_w;

  // Votes only count while the poll is open; clearing happens from CLOSED.
  assign inc_a_w = (state_q == ST_OPEN) && bus.vote_enable && (bus.current_candidate == CAND_A);
  assign inc_b_w = (state_q == ST_OPEN) && bus.vote_enable && (bus.current_candidate == CAND_B);
  assign clr_w   = (state_q == ST_CLOSED) && bus.clear_poll;

  vote_counter_sat #(.CNT_W(CNT_W)) u_cnt_a (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr_w),
    .inc_i   (inc_a_w),
    .count_o (count_a_w),
    .sat_o   (sat_a_w)
  );

  vote_counter_sat #(.CNT_W(CNT_W)) u_cnt_b (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr_w),
    .inc_i   (inc_b_w),
    .count_o (count_b_w),
    .sat_o   (sat_b_w)
  );

  // Poll FSM: ID lookups and marking in OPEN, bitmap audit in SCAN, hold in CLOSED.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_OPEN;
      used_q         <= '0;
      latched_q      <= '0;
      id_valid_q     <= 1'b0;
      id_used_q      <= 1'b0;
      turnout_q      <= '0;
      tsat_q         <= 1'b0;
      scan_idx_q     <= '0;
      winner_q       <= W_NONE;
      result_valid_q <= 1'b0;
      audit_ok_q     <= 1'b0;
      dup_err_q      <= 1'b0;
      poll_open_q    <= 1'b1;
    end else begin
      dup_err_q <= 1'b0;
      unique case (state_q)
        ST_OPEN: begin
          // A mark always refers to the ID latched by an earlier check.
          if (bus.mark_done) begin
            if (used_q[latched_q]) begin
              dup_err_q <= 1'b1;
            end else begin
              used_q[latched_q] <= 1'b1;
              id_valid_q        <= 1'b0;
              id_used_q         <= 1'b1;
            end
          end
          // The lookup sees the pre-mark bitmap, so an ID being marked this
          // same cycle must not be reported as still valid.
          if (bus.check) begin
            latched_q  <= bus.id;
            id_valid_q <= REG_MASK[bus.id] & ~used_q[bus.id]
                          & ~(bus.mark_done & (latched_q == bus.id));
            id_used_q  <= used_q[bus.id];
          end
          if (bus.close_poll) begin
            state_q     <= ST_SCAN;
            poll_open_q <= 1'b0;
            id_valid_q  <= 1'b0;
            scan_idx_q  <= '0;
          end
        end

        ST_SCAN: begin
          dup_err_q <= bus.mark_done;
          if (bus.check) id_used_q <= used_q[bus.id];
          // The extra step after the last index publishes the result from
          // the fully accumulated turnout.
          if (scan_idx_q[ID_W]) begin
            state_q        <= ST_CLOSED;
            result_valid_q <= 1'b1;
            winner_q       <= pick_winner(32'(count_a_w), 32'(count_b_w));
            audit_ok_q     <= ({1'b0, turnout_q} == ({1'b0, count_a_w} + {1'b0, count_b_w}))
                              && !sat_a_w && !sat_b_w && !tsat_q;
          end else begin
            if (used_q[scan_idx_q[ID_W-1:0]]) begin
              if (turnout_q == {CNT_W{1'b1}}) tsat_q <= 1'b1;
              else turnout_q <= turnout_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            scan_idx_q <= scan_idx_q + {{ID_W{1'b0}}, 1'b1};
          end
        end

        ST_CLOSED: begin
          if (bus.clear_poll) begin
            state_q        <= ST_OPEN;
            used_q         <= '0;
            latched_q      <= '0;
            id_valid_q     <= 1'b0;
            id_used_q      <= 1'b0;
            turnout_q      <= '0;
            tsat_q         <= 1'b0;
            scan_idx_q     <= '0;
            winner_q       <= W_NONE;
            result_valid_q <= 1'b0;
            audit_ok_q     <= 1'b0;
            poll_open_q    <= 1'b1;
          end else begin
            dup_err_q <= bus.mark_done;
            if (bus.check) id_used_q <= used_q[bus.id];
          end
        end

        default: state_q <= ST_OPEN;
      endcase
    end
  end

  assign bus.id_valid     = id_valid_q;
  assign bus.id_used      = id_used_q;
  assign bus.count_a      = count_a_w;
  assign bus.count_b      = count_b_w;
  assign bus.turnout      = turnout_q;
  assign bus.winner       = winner_q;
  assign bus.result_valid = result_valid_q;
  assign bus.audit_ok     = audit_ok_q;
  assign bus.dup_err      = dup_err_q;
  assign bus.poll_open    = poll_open_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_registry.sv
`default_nettype none
// ============================================================================
// Module   : tb_vote_registry
// Purpose  : Self-checking bench. Two registries (8-bit counters with ID 0
//            unregistered, and 2-bit counters with all IDs registered) see
//            the same stimulus and are compared each cycle against a
//            behavioural model of the poll rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vote_registry;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] r_id;
  logic       r_check, r_vote, r_cand, r_mark, r_close, r_clear;

  vote_registry_if #(.ID_W(4), .CNT_W(8)) if0 ();
  vote_registry_if #(.ID_W(4), .CNT_W(2)) if1 ();

  assign if0.id = r_id;        assign if1.id = r_id;
  assign if0.check = r_check;  assign if1.check = r_check;
  assign if0.vote_enable = r_vote;  assign if1.vote_enable = r_vote;
  assign if0.current_candidate = r_cand; assign if1.current_candidate = r_cand;
  assign if0.mark_done = r_mark;   assign if1.mark_done = r_mark;
  assign if0.close_poll = r_close; assign if1.close_poll = r_close;
  assign if0.clear_poll = r_clear; assign if1.clear_poll = r_clear;

  vote_registry #(.ID_W(4), .CNT_W(8), .REG_MASK(16'hFFFE)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  vote_registry #(.ID_W(4), .CNT_W(2), .REG_MASK(16'hFFFF)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (one slot per DUT) ----------------
  // Poll phase: 0 open, 1 audit in progress, 2 closed.
  bit [15:0] m_used [2];
  int        m_lat [2], m_ca [2], m_cb [2], m_turn [2], m_phase [2], m_wait [2];
  bit        m_iv [2], m_iu [2], m_rv [2], m_aok [2], m_dup [2], m_open [2];
  int        m_win [2];

  function automatic int cap(int k);   return (k == 0) ? 255 : 3; endfunction
  function automatic bit [15:0] regm(int k); return (k == 0) ? 16'hFFFE : 16'hFFFF; endfunction
  function automatic int clampv(int v, int mx); return (v > mx) ? mx : v; endfunction

  task automatic model_reset(int k);
    m_used[k] = '0; m_lat[k] = 0; m_ca[k] = 0; m_cb[k] = 0; m_turn[k] = 0;
    m_phase[k] = 0; m_wait[k] = 0; m_iv[k] = 0; m_iu[k] = 0; m_rv[k] = 0;
    m_aok[k] = 0; m_dup[k] = 0; m_open[k] = 1; m_win[k] = 0;
  endtask

  task automatic model_publish(int k);
    int pop, a, b, mx;
    mx  = cap(k);
    pop = $countones(m_used[k]);
    a   = clampv(m_ca[k], mx);
    b   = clampv(m_cb[k], mx);
    m_turn[k] = clampv(pop, mx);
    if (a == 0 && b == 0) m_win[k] = 0;
    else if (a > b)       m_win[k] = 1;
    else if (b > a)       m_win[k] = 2;
    else                  m_win[k] = 3;
    m_aok[k]   = (m_turn[k] == a + b) && (m_ca[k] <= mx) && (m_cb[k] <= mx) && (pop <= mx);
    m_rv[k]    = 1;
    m_phase[k] = 2;
  endtask

  task automatic model_step(int k);
    bit [15:0] u_old;
    u_old    = m_used[k];
    m_dup[k] = 0;
    if (m_phase[k] == 0) begin
      if (r_mark) begin
        if (u_old[m_lat[k]]) m_dup[k] = 1;
        else begin m_used[k][m_lat[k]] = 1'b1; m_iv[k] = 0; m_iu[k] = 1; end
      end
      if (r_vote) begin
        if (r_cand) m_cb[k]++; else m_ca[k]++;
      end
      if (r_check) begin
        m_iv[k]  = regm(k)[r_id] && !u_old[r_id] && !(r_mark && m_lat[k] == int'(r_id));
        m_iu[k]  = u_old[r_id];
        m_lat[k] = int'(r_id);
      end
      if (r_close) begin
        m_iv[k] = 0; m_open[k] = 0; m_phase[k] = 1; m_wait[k] = 0;
      end
    end else if (m_phase[k] == 1) begin
      m_dup[k] = r_mark;
      if (r_check) m_iu[k] = u_old[r_id];
      m_wait[k]++;
      // 16 indices scanned plus one publishing cycle
      if (m_wait[k] == 17) model_publish(k);
    end else begin
      if (r_clear) model_reset(k);
      else begin
        m_dup[k] = r_mark;
        if (r_check) m_iu[k] = u_old[r_id];
      end
    end
  endtask

  task automatic cmp_dut(int k, logic iv, logic iu, logic [7:0] ca, logic [7:0] cb,
                         logic [7:0] tu, logic [1:0] win, logic rv, logic aok,
                         logic dup, logic po);
    string p;
    p = $sformatf("d%0d.", k);
    chk({p, "id_valid"}, iv, m_iv[k]);
    chk({p, "id_used"}, iu, m_iu[k]);
    chk({p, "count_a"}, ca, clampv(m_ca[k], cap(k)));
    chk({p, "count_b"}, cb, clampv(m_cb[k], cap(k)));
    if (m_phase[k] != 1) chk({p, "turnout"}, tu, m_turn[k]);
    chk({p, "winner"}, win, m_win[k]);
    chk({p, "result_valid"}, rv, m_rv[k]);
    chk({p, "audit_ok"}, aok, m_aok[k]);
    chk({p, "dup_err"}, dup, m_dup[k]);
    chk({p, "poll_open"}, po, m_open[k]);
  endtask

  task automatic cmp_all();
    cmp_dut(0, if0.id_valid, if0.id_used, if0.count_a, if0.count_b, if0.turnout,
            if0.winner, if0.result_valid, if0.audit_ok, if0.dup_err, if0.poll_open);
    cmp_dut(1, if1.id_valid, if1.id_used, 8'(if1.count_a), 8'(if1.count_b), 8'(if1.turnout),
            if1.winner, if1.result_valid, if1.audit_ok, if1.dup_err, if1.poll_open);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    r_check = 0; r_vote = 0; r_cand = 0; r_mark = 0; r_close = 0; r_clear = 0;
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset_n) begin model_step(0); model_step(1); end
    @(negedge clk);
    cmp_all();
    idle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset(0); model_reset(1);
    @(negedge clk);
    cmp_all();
    reset_n = 1'b1;
  endtask

  task automatic cast(input int vid, input bit cand);
    r_id = 4'(vid); r_check = 1; step();
    r_vote = 1; r_mark = 1; r_cand = cand; step();
  endtask

  // Returns cycles from the current point until result_valid, bounded.
  task automatic wait_result(output int n);
    n = 0;
    while (!if0.result_valid && n < 40) begin step(); n++; end
  endtask

  int lat;

  initial begin
    idle();
    r_id = '0;
    @(negedge clk);
    do_reset();

    // first voter on ID 3, candidate B
    r_id = 4'd3; r_check = 1; step();
    chk("plan.id3_valid", if0.id_valid, 1);
    chk("plan.id3_used", if0.id_used, 0);
    r_vote = 1; r_mark = 1; r_cand = 1; step();
    chk("plan.count_b", if0.count_b, 1);
    chk("plan.after_mark_valid", if0.id_valid, 0);
    chk("plan.after_mark_used", if0.id_used, 1);

    // re-check and forced duplicate mark
    r_id = 4'd3; r_check = 1; step();
    chk("plan.recheck_valid", if0.id_valid, 0);
    chk("plan.recheck_used", if0.id_used, 1);
    r_mark = 1; step();
    chk("plan.dup_pulse", if0.dup_err, 1);
    chk("plan.dup_count_b", if0.count_b, 1);
    step();
    chk("plan.dup_single", if0.dup_err, 0);

    // unregistered ID 0 on the masked instance
    r_id = 4'd0; r_check = 1; step();
    chk("plan.unreg_valid", if0.id_valid, 0);
    chk("plan.unreg_used", if0.id_used, 0);
    chk("plan.reg_valid_d1", if1.id_valid, 1);

    // IDs 1,2,5 for A and 7 for B, then audit
    do_reset();
    cast(1, 0); cast(2, 0); cast(5, 0); cast(7, 1);
    r_close = 1; step();
    wait_result(lat);
    chk("plan.latency", lat, 17);
    chk("plan.turnout", if0.turnout, 4);
    chk("plan.count_a", if0.count_a, 3);
    chk("plan.count_b1", if0.count_b, 1);
    chk("plan.winner", if0.winner, 1);
    chk("plan.audit_ok", if0.audit_ok, 1);
    chk("plan.d1_audit_sat", if1.audit_ok, 0);

    // vote in the close cycle counts; votes during the scan do not
    r_clear = 1; step();
    chk("plan.reopen", if0.poll_open, 1);
    r_id = 4'd4; r_check = 1; step();
    r_vote = 1; r_mark = 1; r_cand = 0; r_close = 1; step();
    for (int i = 0; i < 3; i++) begin r_vote = 1; r_cand = 0; step(); end
    wait_result(lat);
    chk("plan.close_vote_a", if0.count_a, 1);
    chk("plan.close_winner", if0.winner, 1);
    r_clear = 1; step();
    chk("plan.clear_a", if0.count_a, 0);
    chk("plan.clear_rv", if0.result_valid, 0);
    chk("plan.clear_open", if0.poll_open, 1);

    // saturation on the 2-bit instance
    cast(1, 0); cast(2, 0); cast(3, 0); cast(4, 0);
    r_close = 1; step();
    wait_result(lat);
    chk("plan.sat_count_a", if1.count_a, 3);
    chk("plan.sat_audit", if1.audit_ok, 0);
    chk("plan.nosat_audit", if0.audit_ok, 1);

    // reset in the middle of a scan
    r_clear = 1; step();
    cast(6, 1);
    r_close = 1; step();
    for (int i = 0; i < 5; i++) step();
    do_reset();
    chk("plan.midscan_open", if0.poll_open, 1);
    chk("plan.midscan_b", if0.count_b, 0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      r_id    = 4'($urandom_range(0, 15));
      r_check = ($urandom_range(0, 2) == 0);
      r_vote  = ($urandom_range(0, 3) == 0);
      r_cand  = 1'($urandom_range(0, 1));
      r_mark  = r_vote ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
      r_close = ($urandom_range(0, 59) == 0);
      r_clear = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vote_registry.md
Name: vote_registry

Overview:
- Responder side of the voting controller handshake.
- Answers the controller's ID checks by driving id_valid and id_used, and takes its vote_enable/mark_done strobes to tally votes per candidate and record used voter IDs.
- On poll close, a sequential audit scans the used-ID bitmap, checks turnout against the tallies and publishes the winner.
- Sits beside the controller and shares the same id and check inputs.

Parameters:
- ID_W, 4, voter ID width; NUM_IDS = 2**ID_W.
- CNT_W, 8, width of each candidate counter and of turnout.
- REG_MASK, {NUM_IDS{1'b1}}, bit i set = ID i is registered (eligible).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- id  in  ID_W  voter ID presented to the machine.
- check  in  1  ID check request; same signal the controller sees.
- vote_enable  in  1  controller strobe: a vote is being cast this cycle.
- current_candidate  in  1  candidate for this vote (0=A, 1=B); valid with vote_enable.
- mark_done  in  1  controller strobe: mark the latched ID as used.
- close_poll  in  1  pulse: end voting and start the audit.
- clear_poll  in  1  pulse: only in CLOSED; reopen with all state cleared.
- id_valid  out  1  latched ID is registered, unused and the poll is open.
- id_used  out  1  latched ID has already voted.
- count_a, count_b  out  CNT_W  per-candidate tallies.
- turnout  out  CNT_W  popcount of the used bitmap; valid when result_valid=1.
- winner  out  2  00 none (no votes), 01 A, 10 B, 11 tie; valid when result_valid=1.
- result_valid  out  1  high in CLOSED.
- audit_ok  out  1  turnout == count_a+count_b and no saturation; valid when result_valid=1.
- dup_err  out  1  one-cycle pulse: mark attempted on an already-used ID or while not OPEN.
- poll_open  out  1  high in OPEN.

Behaviour:
- Reset (async, reset_n=0): state OPEN; used bitmap, latched_id, count_a, count_b, turnout, winner = 0; id_valid, id_used, result_valid, audit_ok, dup_err = 0; poll_open = 1.
- States: OPEN, SCAN, CLOSED.
- OPEN, check=1 at edge t: latched_id <= id.
  - id_valid <= REG_MASK[id] & ~used[id].
  - id_used <= used[id].
  - Both are visible in cycle t+1, which is when the controller evaluates them.
  - Both hold until the next check or a mark.
- OPEN, vote_enable=1:
  - current_candidate=0 increments count_a; =1 increments count_b.
  - Counters saturate at 2**CNT_W-1 and set an internal sat flag.
- OPEN, mark_done=1:
  - If used[latched_id]=0: set it, and next cycle id_valid=0 and id_used=1.
  - If already set: bitmap unchanged, dup_err pulses.
- vote_enable and mark_done in the same cycle (the normal case) both take effect at that edge.
- check in the same cycle as mark_done: the mark uses the old latched_id, and the lookup uses the new id against the pre-update bitmap. If the two IDs are equal, id_valid=0 is forced.
- close_poll in OPEN:
  - Any vote or mark in that cycle is still applied.
  - Next state SCAN; poll_open=0, and id_valid is forced to 0.
- SCAN:
  - Runs one bitmap index per cycle, 0 to NUM_IDS-1, accumulating turnout (saturating).
  - After index NUM_IDS-1, the cycle that enters CLOSED computes winner and audit_ok; result_valid=1 in that cycle.
  - Latency from the close_poll edge to result_valid = NUM_IDS+1 cycles.
- In SCAN and CLOSED: vote_enable is ignored; mark_done pulses dup_err; check updates id_used only, and id_valid stays 0.
- Winner rule:
  - both tallies 0 → 00;
  - count_a > count_b → 01;
  - count_b > count_a → 10;
  - equal and nonzero → 11.
- CLOSED:
  - Outputs hold.
  - clear_poll → OPEN, clearing the bitmap, counters, turnout, flags and outputs to their reset values.
  - clear_poll in OPEN or SCAN is ignored; close_poll outside OPEN is ignored.
- Reset asserted mid-SCAN aborts the scan and returns to the reset state.

Decomposition:
- Shared package voting_pkg:
  - state encodings (OPEN/SCAN/CLOSED);
  - winner codes (W_NONE, W_A, W_B, W_TIE);
  - candidate codes (CAND_A=0, CAND_B=1).
- One natural sub-module: vote_counter_sat (CNT_W saturating up-counter with a sync clear and a sat flag), instantiated twice for the tallies.
- The turnout accumulator stays inline.

Test Plan:
- Reset, then check with id=3 → next cycle id_valid=1, id_used=0. vote_enable+mark_done with cand=1 → count_b=1; next cycle id_valid=0, id_used=1.
- Re-check id=3 after it voted → id_valid=0, id_used=1. Forced mark_done → dup_err pulses once and count_b stays 1.
- REG_MASK=16'hFFFE, check id=0 → id_valid=0, id_used=0.
- Votes: IDs 1,2,5 for A and 7 for B, then close_poll → result_valid exactly 17 cycles after the close_poll edge, with turnout=4, count_a=3, count_b=1, winner=01, audit_ok=1.
- close_poll in the same cycle as vote_enable → that vote is counted. Then vote_enable during SCAN → ignored. Then clear_poll in CLOSED → all zero, poll_open=1.
- CNT_W=2, four A votes → count_a=3 (saturated) and audit_ok=0. Also: reset_n low mid-SCAN → state OPEN with all outputs at reset values.
